// File: rtl/ofs_plat_avalon_mem_rd_credit_pkg.sv
// Shared types for the Avalon read credit limiter.
//   t_line_cnt : wide arithmetic type for line-count sums; wide enough that
//                "active + burstcount" never wraps for any legal configuration.
//   t_wr_state : write-burst tracker states (IDLE / BURST).
//   burst_eff  : burstcount as charged to the counters (a zero burst counts as 1).
package ofs_plat_avalon_mem_rd_credit_pkg;

    localparam int LINE_CNT_W = 32;

    typedef logic [LINE_CNT_W-1:0] t_line_cnt;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } t_wr_state;

    function automatic t_line_cnt burst_eff(input t_line_cnt bc);
        return (bc == '0) ? t_line_cnt'(1) : bc;
    endfunction

endpackage

// File: rtl/ofs_plat_avalon_mem_wr_burst_tracker.sv
// Write-burst beat tracker and write-response generator.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   i_beat_accept  : a write beat is accepted this cycle
//   i_burstcount   : burstcount, sampled only on the first beat of a burst
//   o_in_burst     : a multi-beat write burst is in progress (past its first beat)
//   o_wr_resp      : one-cycle pulse, the cycle after a burst's final beat is accepted
module ofs_plat_avalon_mem_wr_burst_tracker
    import ofs_plat_avalon_mem_rd_credit_pkg::*;
#(
    parameter int BURST_CNT_WIDTH = 7
)
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_beat_accept,
    input  logic [BURST_CNT_WIDTH-1:0] i_burstcount,
    output logic                       o_in_burst,
    output logic                       o_wr_resp
);

    t_wr_state                  r_state;
    logic [BURST_CNT_WIDTH-1:0] r_beats_left;
    logic                       r_wr_resp;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_beats_left <= '0;
            r_wr_resp    <= 1'b0;
        end else begin
            r_wr_resp <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_beat_accept) begin
                        // burstcount 0 and 1 are both single-beat writes
                        if (i_burstcount > BURST_CNT_WIDTH'(1)) begin
                            r_state      <= BURST;
                            r_beats_left <= i_burstcount - BURST_CNT_WIDTH'(1);
                        end else begin
                            r_wr_resp <= 1'b1;
                        end
                    end
                end
                BURST: begin
                    if (i_beat_accept) begin
                        if (r_beats_left == BURST_CNT_WIDTH'(1)) begin
                            r_state      <= IDLE;
                            r_beats_left <= '0;
                            r_wr_resp    <= 1'b1;
                        end else begin
                            r_beats_left <= r_beats_left - BURST_CNT_WIDTH'(1);
                        end
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_beats_left <= '0;
                end
            endcase
        end
    end

    assign o_in_burst = (r_state == BURST);
    assign o_wr_resp  = r_wr_resp;

endmodule

// File: rtl/ofs_plat_avalon_mem_rd_credit_limiter.sv
// Avalon-MM read credit limiter. Holds off new read bursts whenever accepting
// them would push the number of outstanding read lines above MAX_ACTIVE_LINES.
// Writes and read responses pass through; write bursts get a generated
// writeresponsevalid.
// Ports:
//   clk, reset              : clock, asynchronous active-high reset
//   src_*                   : slave-side Avalon port (from the master)
//   snk_*                   : master-side Avalon port (to memory)
//   active_lines            : outstanding read lines
//   err                     : sticky protocol error (orphan response, zero burst)
// Optional build macro OFS_PLAT_AVMEM_RD_CREDIT_STATS_EN adds:
//   peak_active_lines       : high-water mark of active_lines
//   blocked_cycles          : saturating count of cycles a read was held off
module ofs_plat_avalon_mem_rd_credit_limiter
    import ofs_plat_avalon_mem_rd_credit_pkg::*;
#(
    parameter int ADDR_WIDTH       = 27,
    parameter int DATA_WIDTH       = 512,
    parameter int BURST_CNT_WIDTH  = 7,
    parameter int MAX_ACTIVE_LINES = 512,
    localparam int LINE_W          = $clog2(MAX_ACTIVE_LINES + 1)
)
(
    input  logic                       clk,
    input  logic                       reset,

    input  logic                       src_read,
    input  logic                       src_write,
    input  logic [ADDR_WIDTH-1:0]      src_address,
    input  logic [BURST_CNT_WIDTH-1:0] src_burstcount,
    input  logic [DATA_WIDTH-1:0]      src_writedata,
    input  logic [DATA_WIDTH/8-1:0]    src_byteenable,
    output logic                       src_waitrequest,
    output logic [DATA_WIDTH-1:0]      src_readdata,
    output logic                       src_readdatavalid,
    output logic                       src_writeresponsevalid,

    output logic                       snk_read,
    output logic                       snk_write,
    output logic [ADDR_WIDTH-1:0]      snk_address,
    output logic [BURST_CNT_WIDTH-1:0] snk_burstcount,
    output logic [DATA_WIDTH-1:0]      snk_writedata,
    output logic [DATA_WIDTH/8-1:0]    snk_byteenable,
    input  logic                       snk_waitrequest,
    input  logic [DATA_WIDTH-1:0]      snk_readdata,
    input  logic                       snk_readdatavalid,

    output logic [LINE_W-1:0]          active_lines,
    output logic                       err
`ifdef OFS_PLAT_AVMEM_RD_CREDIT_STATS_EN
    ,
    output logic [LINE_W-1:0]          peak_active_lines,
    output logic [31:0]                blocked_cycles
`endif
);

    logic              w_rd_block;
    logic              w_in_burst;
    logic              w_rd_accept;
    logic              w_wr_accept;
    logic              w_wr_first;
    logic              w_bc_zero;
    logic              w_orphan_rsp;
    t_line_cnt         w_bc_eff;
    t_line_cnt         w_active_ext;
    t_line_cnt         w_active_next;

    logic [LINE_W-1:0] r_active;
    logic              r_err;

    assign w_active_ext = t_line_cnt'(r_active);
    assign w_bc_eff     = burst_eff(t_line_cnt'(src_burstcount));
    assign w_bc_zero    = (src_burstcount == '0);

    // Mid-burst write beats carry no meaningful burstcount, so never block them.
    assign w_rd_block = src_read & ~w_in_burst &
                        ((w_active_ext + w_bc_eff) > t_line_cnt'(MAX_ACTIVE_LINES));

    assign snk_read        = src_read  & ~w_rd_block;
    assign snk_write       = src_write & ~w_rd_block;
    assign snk_address     = src_address;
    assign snk_burstcount  = src_burstcount;
    assign snk_writedata   = src_writedata;
    assign snk_byteenable  = src_byteenable;
    assign src_waitrequest = snk_waitrequest | w_rd_block;

    assign src_readdata      = snk_readdata;
    assign src_readdatavalid = snk_readdatavalid;

    assign w_rd_accept  = src_read  & ~src_waitrequest;
    assign w_wr_accept  = src_write & ~src_waitrequest;
    assign w_wr_first   = w_wr_accept & ~w_in_burst;
    assign w_orphan_rsp = snk_readdatavalid & (r_active == '0);

    // A response with nothing outstanding is not counted against the new total.
    always_comb begin
        w_active_next = w_active_ext + (w_rd_accept ? w_bc_eff : '0);
        if (snk_readdatavalid && !w_orphan_rsp) begin
            w_active_next = w_active_next - t_line_cnt'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_active <= '0;
            r_err    <= 1'b0;
        end else begin
            r_active <= LINE_W'(w_active_next);
            r_err    <= r_err | w_orphan_rsp | ((w_rd_accept | w_wr_first) & w_bc_zero);
        end
    end

    assign active_lines = r_active;
    assign err          = r_err;

    ofs_plat_avalon_mem_wr_burst_tracker #(
        .BURST_CNT_WIDTH (BURST_CNT_WIDTH)
    ) u_wr_tracker (
        .clk           (clk),
        .reset         (reset),
        .i_beat_accept (w_wr_accept),
        .i_burstcount  (src_burstcount),
        .o_in_burst    (w_in_burst),
        .o_wr_resp     (src_writeresponsevalid)
    );

`ifdef OFS_PLAT_AVMEM_RD_CREDIT_STATS_EN
    logic [LINE_W-1:0] r_peak;
    logic [31:0]       r_blocked;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_peak    <= '0;
            r_blocked <= '0;
        end else begin
            if (r_active > r_peak) begin
                r_peak <= r_active;
            end
            if (w_rd_block && (r_blocked != '1)) begin
                r_blocked <= r_blocked + 32'd1;
            end
        end
    end

    assign peak_active_lines = r_peak;
    assign blocked_cycles    = r_blocked;
`endif

endmodule

// File: tb/tb_ofs_plat_avalon_mem_rd_credit_limiter.sv
// Scoreboard bench for the Avalon read credit limiter: directed scenarios
// followed by randomized traffic, checked against a line-count/beat-count
// reference model. Read responses and write responses are checked by a
// separate monitor that pops expected items from queues.
module tb_ofs_plat_avalon_mem_rd_credit_limiter;

    localparam int AW   = 16;
    localparam int DW   = 32;
    localparam int BW   = 4;
    localparam int MAXL = 8;
    localparam int LW   = $clog2(MAXL + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          src_read = 1'b0, src_write = 1'b0;
    logic [AW-1:0] src_address = '0;
    logic [BW-1:0] src_burstcount = '0;
    logic [DW-1:0] src_writedata = '0;
    logic [DW/8-1:0] src_byteenable = '0;
    logic          src_waitrequest;
    logic [DW-1:0] src_readdata;
    logic          src_readdatavalid, src_writeresponsevalid;
    logic          snk_read, snk_write;
    logic [AW-1:0] snk_address;
    logic [BW-1:0] snk_burstcount;
    logic [DW-1:0] snk_writedata;
    logic [DW/8-1:0] snk_byteenable;
    logic          snk_waitrequest = 1'b0;
    logic [DW-1:0] snk_readdata = '0;
    logic          snk_readdatavalid = 1'b0;
    logic [LW-1:0] active_lines;
    logic          err;

    always #5 clk = ~clk;

    ofs_plat_avalon_mem_rd_credit_limiter #(
        .ADDR_WIDTH       (AW),
        .DATA_WIDTH       (DW),
        .BURST_CNT_WIDTH  (BW),
        .MAX_ACTIVE_LINES (MAXL)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .src_read               (src_read),
        .src_write              (src_write),
        .src_address            (src_address),
        .src_burstcount         (src_burstcount),
        .src_writedata          (src_writedata),
        .src_byteenable         (src_byteenable),
        .src_waitrequest        (src_waitrequest),
        .src_readdata           (src_readdata),
        .src_readdatavalid      (src_readdatavalid),
        .src_writeresponsevalid (src_writeresponsevalid),
        .snk_read               (snk_read),
        .snk_write              (snk_write),
        .snk_address            (snk_address),
        .snk_burstcount         (snk_burstcount),
        .snk_writedata          (snk_writedata),
        .snk_byteenable         (snk_byteenable),
        .snk_waitrequest        (snk_waitrequest),
        .snk_readdata           (snk_readdata),
        .snk_readdatavalid      (snk_readdatavalid),
        .active_lines           (active_lines),
        .err                    (err)
    );

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int          cyc = 0;

    // Reference model: outstanding lines, sticky error, remaining write beats.
    int          m_out = 0;
    bit          m_err = 1'b0;
    int          m_wr_left = 0;

    logic [DW-1:0] rd_q[$];
    int            wr_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Response monitor
    initial begin
        forever begin
            bit            exp_v;
            logic [DW-1:0] exp_d;
            @(negedge clk);
            #2;
            exp_v = (rd_q.size() != 0);
            chk("readdatavalid", longint'(src_readdatavalid), longint'(exp_v));
            if (exp_v) begin
                exp_d = rd_q.pop_front();
                chk("readdata", longint'(src_readdata), longint'(exp_d));
            end
            exp_v = (wr_q.size() != 0) && (wr_q[0] == cyc);
            chk("writeresponsevalid", longint'(src_writeresponsevalid), longint'(exp_v));
            if (exp_v) void'(wr_q.pop_front());
        end
    end

    task automatic step(input bit rd, input bit wr, input logic [BW-1:0] bc,
                        input bit rdv, input bit swait);
        int            eff;
        bit            blk, wt, racc, wacc;
        int            n;
        logic [AW-1:0] a;
        logic [DW-1:0] wd, rdd;
        logic [DW/8-1:0] be;
        @(negedge clk);
        chk("active_lines", longint'(active_lines), longint'(m_out));
        chk("err", longint'(err), longint'(m_err));
        a   = AW'($urandom);
        wd  = $urandom;
        be  = (DW/8)'($urandom);
        rdd = $urandom;
        src_read = rd; src_write = wr; src_burstcount = bc;
        src_address = a; src_writedata = wd; src_byteenable = be;
        snk_waitrequest = swait; snk_readdatavalid = rdv; snk_readdata = rdd;
        if (rdv) rd_q.push_back(rdd);
        #1;
        eff  = (bc == 0) ? 1 : int'(bc);
        blk  = rd && (m_wr_left == 0) && (m_out + eff > MAXL);
        wt   = swait || blk;
        chk("src_waitrequest", longint'(src_waitrequest), longint'(wt));
        chk("snk_read", longint'(snk_read), longint'(rd && !blk));
        chk("snk_write", longint'(snk_write), longint'(wr && !blk));
        chk("snk_address", longint'(snk_address), longint'(a));
        chk("snk_burstcount", longint'(snk_burstcount), longint'(bc));
        chk("snk_writedata", longint'(snk_writedata), longint'(wd));
        chk("snk_byteenable", longint'(snk_byteenable), longint'(be));
        racc = rd && !wt;
        wacc = wr && !wt;
        if ((racc || (wacc && m_wr_left == 0)) && bc == 0) m_err = 1'b1;
        if (rdv && m_out == 0) begin
            m_err = 1'b1;
            m_out = racc ? eff : 0;
        end else begin
            m_out = m_out + (racc ? eff : 0) - (rdv ? 1 : 0);
        end
        if (wacc) begin
            n = (m_wr_left == 0) ? eff : m_wr_left;
            n--;
            m_wr_left = n;
            if (n == 0) wr_q.push_back(cyc + 1);
        end
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        while (m_out > 0) step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        src_read = 1'b0; src_write = 1'b0; snk_readdatavalid = 1'b0; snk_waitrequest = 1'b0;
        m_out = 0; m_err = 1'b0; m_wr_left = 0;
        wr_q.delete();
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("rst_active_lines", longint'(active_lines), 0);
            chk("rst_err", longint'(err), 0);
            chk("rst_wrresp", longint'(src_writeresponsevalid), 0);
            @(negedge clk);
        end
        reset = 1'b0;
    endtask

    initial begin
        do_reset();

        // Credit exhaustion: 4 + 4 fills the limit, the 1-line read is held off
        step(1'b1, 1'b0, 4'd4, 1'b0, 1'b0);
        step(1'b1, 1'b0, 4'd4, 1'b0, 1'b0);
        step(1'b1, 1'b0, 4'd1, 1'b0, 1'b0);
        // Still full; one response frees a line, read goes next cycle
        step(1'b1, 1'b0, 4'd1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 4'd1, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk("full_after_refill", longint'(active_lines), 8);
        drain();

        // Accept and response in the same cycle: 2 + 4 - 1
        do_reset();
        step(1'b1, 1'b0, 4'd2, 1'b0, 1'b0);
        step(1'b1, 1'b0, 4'd4, 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk("same_cycle_update", longint'(active_lines), 5);
        drain();

        // Exact-fit burst, then a zero burst (counted as 1, flags err)
        step(1'b1, 1'b0, 4'd8, 1'b0, 1'b0);
        step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        drain();
        step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        drain();

        // Orphan response: count holds at 0, err sticks until reset
        do_reset();
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        idle(3);
        chk("orphan_err_sticky", longint'(err), 1);
        do_reset();

        // 3-beat write with waitrequest toggling; non-first burstcounts are junk
        step(1'b0, 1'b1, 4'd3, 1'b0, 1'b1);
        step(1'b0, 1'b1, 4'd3, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'd7, 1'b0, 1'b1);
        step(1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'd9, 1'b0, 1'b0);
        idle(3);

        // Reset during beat 2 of a 4-beat write, then a fresh single write
        step(1'b0, 1'b1, 4'd4, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'd5, 1'b0, 1'b0);
        do_reset();
        step(1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
        idle(3);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            bit            rd, wr, rdv, sw;
            logic [BW-1:0] bc;
            sw  = ($urandom % 4) == 0;
            rdv = (m_out > 0) && ($urandom % 2 == 1);
            rd  = 1'b0;
            wr  = 1'b0;
            if (m_wr_left > 0) begin
                wr = ($urandom % 4) != 0;
            end else begin
                case ($urandom % 3)
                    0: rd = 1'b1;
                    1: wr = 1'b1;
                    default: ;
                endcase
            end
            bc = (($urandom % 16) == 0) ? '0 : BW'($urandom_range(1, MAXL));
            step(rd, wr, bc, rdv, sw);
        end
        while (m_wr_left > 0) step(1'b0, 1'b1, '0, 1'b0, 1'b0);
        drain();
        idle(3);
        chk("wrresp_queue_empty", longint'(wr_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ofs_plat_avalon_mem_rd_credit_limiter.md
OFS_PLAT_AVALON_MEM_RD_CREDIT_LIMITER -- requirements
Module: ofs_plat_avalon_mem_rd_credit_limiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 27, word address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 512, data bus width; byteenable width is DATA_WIDTH/8.
REQ-003 SHALL have parameter BURST_CNT_WIDTH, default 7, burstcount width.
REQ-004 SHALL have parameter MAX_ACTIVE_LINES, default 512, maximum outstanding read lines; must be at least 2^(BURST_CNT_WIDTH-1).
REQ-005 SHALL use one clock and an asynchronous, active-high reset.
REQ-006 SHALL have ports: clk in 1 clock; reset in 1 async active-high reset.
REQ-007 SHALL have source-side ports: src_read in 1; src_write in 1; src_address in ADDR_WIDTH; src_burstcount in BURST_CNT_WIDTH; src_writedata in DATA_WIDTH; src_byteenable in DATA_WIDTH/8; src_waitrequest out 1; src_readdata out DATA_WIDTH; src_readdatavalid out 1; src_writeresponsevalid out 1.
REQ-008 SHALL have sink-side ports: snk_read out 1; snk_write out 1; snk_address out ADDR_WIDTH; snk_burstcount out BURST_CNT_WIDTH; snk_writedata out DATA_WIDTH; snk_byteenable out DATA_WIDTH/8; snk_waitrequest in 1; snk_readdata in DATA_WIDTH; snk_readdatavalid in 1.
REQ-009 SHALL have status ports: active_lines out clog2(MAX_ACTIVE_LINES+1), the current outstanding read count; err out 1, a sticky protocol error flag.

Function
REQ-010 SHALL pass request fields combinationally: snk_read = src_read & ~rd_block; snk_write = src_write & ~rd_block; all other request fields wired straight through.
REQ-011 SHALL drive src_waitrequest = snk_waitrequest | rd_block.
REQ-012 SHALL assert rd_block when src_read=1, no write burst is in progress, and active_lines + src_burstcount > MAX_ACTIVE_LINES; rd_block SHALL be 0 otherwise.
REQ-013 SHALL count a read as accepted when src_read & ~src_waitrequest, and SHALL add src_burstcount to active_lines on acceptance.
REQ-014 SHALL decrement active_lines by 1 on each snk_readdatavalid.
REQ-015 SHALL update active_lines by burstcount-1 when a read is accepted and readdatavalid arrives in the same cycle.
REQ-016 SHALL pass snk_readdata/snk_readdatavalid to src_readdata/src_readdatavalid with zero latency.
REQ-017 SHALL track write bursts with a beat counter in states IDLE and BURST: IDLE to BURST on an accepted first beat with burstcount>1, holding burstcount-1 remaining; BURST decrements per accepted beat and returns to IDLE at 0.
REQ-018 SHALL assert src_writeresponsevalid for exactly one cycle, one cycle after the final beat of each write burst is accepted; a burstcount=1 write is its own final beat.
REQ-019 SHALL ignore src_burstcount and src_address on non-first write beats.
REQ-020 SHALL, on readdatavalid while active_lines=0, hold active_lines at 0 and set err.
REQ-021 SHALL treat an accepted request with burstcount=0 as burstcount 1 and set err.
REQ-022 SHALL clear err only on reset.

Reset
REQ-023 SHALL, while reset is asserted, force active_lines=0, err=0, the beat counter to IDLE, and src_writeresponsevalid=0.
REQ-024 SHALL discard any write burst or outstanding reads in flight when reset is asserted mid-operation; responses arriving after reset SHALL follow REQ-020.

Configuration
REQ-025 SHALL, when OFS_PLAT_AVMEM_RD_CREDIT_STATS_EN is defined, add output peak_active_lines (same width as active_lines), a high-water mark of active_lines reset to 0 on reset, plus output blocked_cycles (32 bits), a saturating count of cycles with rd_block=1.
REQ-026 SHALL, when OFS_PLAT_AVMEM_RD_CREDIT_STATS_EN is undefined, omit both ports and their logic.

Structure
REQ-027 SHALL place t_line_cnt and the IDLE/BURST state enum in package ofs_plat_avalon_mem_rd_credit_pkg.
REQ-028 SHALL implement write-burst tracking and response generation in sub-module ofs_plat_avalon_mem_wr_burst_tracker.

Verification
REQ-029 SHALL cover: MAX_ACTIVE_LINES=8; reads of burstcount 4, then 4, then 1 with no responses -> third read blocked, src_waitrequest=1, active_lines=8.
REQ-030 SHALL cover: active_lines=8 with a pending read of burstcount 1 and one readdatavalid -> read accepted in the next cycle, active_lines=8.
REQ-031 SHALL cover: a write of burstcount 3, with snk_waitrequest toggling -> exactly one writeresponsevalid, one cycle after the third accepted beat.
REQ-032 SHALL cover: accepted read of burstcount 4 in the same cycle as readdatavalid, with active_lines=2 -> active_lines=5.
REQ-033 SHALL cover: readdatavalid with active_lines=0 -> active_lines stays 0, err=1 until reset.
REQ-034 SHALL cover: reset asserted mid write burst (beat 2 of 4) -> next write is treated as a first beat and yields one response.
